// File: rtl/timer_sched.sv
// Round-robin scheduler that lends one shared one-shot countdown timer to four
// requesters. It powers the timer up, loads the owner's value and reports completion.
module timer_sched #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_value,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        err,
    output logic        busy,
    output logic        tmr_on,
    output logic        tmr_off,
    output logic        tmr_ok,
    output logic        tmr_mode,
    output logic [7:0]  tmr_value,
    input  logic [7:0]  tmr_out
);

    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POWER = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ABORT = 3'd5
    } state_t;

    state_t        state_r;
    logic [1:0]    rr_ptr_r;
    logic [1:0]    owner_r;
    logic [7:0]    val_q_r;
    logic [WW-1:0] wait_r;
    logic [3:0]    grant_r;
    logic [3:0]    done_r;
    logic          err_r;
    logic          tmr_on_r;
    logic          tmr_off_r;
    logic          tmr_ok_r;

    logic [7:0]    req_dbl_s;
    logic [1:0]    offs_s;
    logic [1:0]    pick_s;
    logic          owner_req_s;
    logic          timeout_s;

    // Rotating the request vector by rr_ptr turns round robin into a fixed priority pick.
    assign req_dbl_s   = {req, req} >> rr_ptr_r;
    assign pick_s      = rr_ptr_r + offs_s;
    assign owner_req_s = req[owner_r];
    assign timeout_s   = (wait_r == WW'(TIMEOUT - 1)) && (tmr_out != 8'h00);

    // Lowest set bit of the rotated request vector gives the offset from rr_ptr
    always_comb begin
        offs_s = 2'd0;
        if (req_dbl_s[0]) begin
            offs_s = 2'd0;
        end else if (req_dbl_s[1]) begin
            offs_s = 2'd1;
        end else if (req_dbl_s[2]) begin
            offs_s = 2'd2;
        end else begin
            offs_s = 2'd3;
        end
    end

    // Scheduler state, timer handshakes and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            rr_ptr_r  <= 2'd0;
            owner_r   <= 2'd0;
            val_q_r   <= 8'd0;
            wait_r    <= {WW{1'b0}};
            grant_r   <= 4'd0;
            done_r    <= 4'd0;
            err_r     <= 1'b0;
            tmr_on_r  <= 1'b0;
            tmr_off_r <= 1'b0;
            tmr_ok_r  <= 1'b0;
        end else begin
            done_r    <= 4'd0;
            err_r     <= 1'b0;
            tmr_on_r  <= 1'b0;
            tmr_off_r <= 1'b0;
            tmr_ok_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req != 4'd0) begin
                        state_r  <= ST_POWER;
                        owner_r  <= pick_s;
                        grant_r  <= 4'b0001 << pick_s;
                        val_q_r  <= req_value[{pick_s, 3'b000} +: 8];
                        wait_r   <= {WW{1'b0}};
                        tmr_on_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_POWER: begin
                    // Cancel outranks timeout, which outranks the normal power-up exit
                    if (!owner_req_s) begin
                        state_r   <= ST_ABORT;
                        tmr_off_r <= 1'b1;
                    end else if (timeout_s) begin
                        state_r   <= ST_ABORT;
                        tmr_off_r <= 1'b1;
                        err_r     <= 1'b1;
                    end else if (tmr_out == 8'h00) begin
                        state_r  <= ST_LOAD;
                        tmr_ok_r <= 1'b1;
                    end else begin
                        wait_r <= wait_r + WW'(1);
                    end
                end
                ST_LOAD: begin
                    if (!owner_req_s) begin
                        state_r   <= ST_ABORT;
                        tmr_off_r <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Only the return to FF ends the run; 00 setup and count values do not
                    if (!owner_req_s) begin
                        state_r   <= ST_ABORT;
                        tmr_off_r <= 1'b1;
                    end else if (tmr_out == 8'hFF) begin
                        state_r <= ST_DONE;
                        done_r  <= grant_r;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE, ST_ABORT: begin
                    state_r  <= ST_IDLE;
                    grant_r  <= 4'd0;
                    rr_ptr_r <= owner_r + 2'd1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= 4'd0;
                end
            endcase
        end
    end

    assign grant     = grant_r;
    assign done      = done_r;
    assign err       = err_r;
    assign busy      = (state_r != ST_IDLE);
    assign tmr_on    = tmr_on_r;
    assign tmr_off   = tmr_off_r;
    assign tmr_ok    = tmr_ok_r;
    assign tmr_mode  = 1'b0;
    assign tmr_value = val_q_r;

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: a one-shot timer model, a transaction-level reference model
// compared every cycle, and directed scenarios with hand-computed expectations.
module tb_timer_sched;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'd0;
    logic [31:0] req_value = 32'd0;
    logic [3:0]  grant, done;
    logic        err, busy, tmr_on, tmr_off, tmr_ok, tmr_mode;
    logic [7:0]  tmr_value, tmr_out;

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    int fixed_pu = 2;
    logic force_stuck = 1'b0;
    logic rand_timer = 1'b0;

    logic [3:0] rr_exp [5];

    timer_sched #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_value(req_value),
        .grant(grant), .done(done), .err(err), .busy(busy),
        .tmr_on(tmr_on), .tmr_off(tmr_off), .tmr_ok(tmr_ok), .tmr_mode(tmr_mode),
        .tmr_value(tmr_value), .tmr_out(tmr_out)
    );

    always #5 clk = ~clk;

    // Timer: 0 off, 1 powering up, 2 awaiting ok, 3 setup, 4 counting, 5 stuck powering
    int tm_st = 0;
    int tm_cnt = 0;
    int tm_pu = 0;

    always @(posedge clk) begin
        if (reset || tmr_off) begin
            tm_st <= 0;
        end else begin
            case (tm_st)
                0: if (tmr_on) begin
                    if (force_stuck || (rand_timer && $urandom_range(0, 11) == 0)) begin
                        tm_st <= 5;
                    end else begin
                        tm_st <= 1;
                        tm_pu <= (fixed_pu >= 0) ? fixed_pu : int'($urandom_range(0, 4));
                    end
                end
                1: if (tm_pu == 0) tm_st <= 2; else tm_pu <= tm_pu - 1;
                2: if (tmr_ok) begin tm_st <= 3; tm_cnt <= int'(tmr_value); end
                3: tm_st <= 4;
                4: if (tm_cnt == 0) tm_st <= 0; else tm_cnt <= tm_cnt - 1;
                default: ;
            endcase
        end
    end

    assign tmr_out = (tm_st == 2 || tm_st == 3) ? 8'h00 : (tm_st == 4) ? tm_cnt[7:0] : 8'hFF;

    // Reference model. ph: 0 idle, 1 power-up, 2 load, 3 counting, 4 done, 5 abort
    typedef struct {
        int ph; int own; int ptr; int val; int wt;
        logic [3:0] g; logic [3:0] d; logic er; logic on; logic off; logic ok;
    } mdl_t;

    mdl_t m = '{default: 0};

    function automatic mdl_t model_next(input mdl_t s, input logic rst, input logic [3:0] rq,
                                        input logic [31:0] rv, input logic [7:0] to);
        mdl_t n = s;
        n.d = 4'd0; n.er = 1'b0; n.on = 1'b0; n.off = 1'b0; n.ok = 1'b0;
        if (rst) begin
            n.ph = 0; n.own = 0; n.ptr = 0; n.val = 0; n.wt = 0; n.g = 4'd0;
            return n;
        end
        case (s.ph)
            0: for (int k = 0; k < 4; k++) begin
                if (n.ph == 0 && rq[(s.ptr + k) % 4]) begin
                    n.own = (s.ptr + k) % 4;
                    n.ph  = 1;
                    n.val = int'(rv[8*n.own +: 8]);
                    n.wt  = 0;
                    n.on  = 1'b1;
                    n.g   = 4'b0001 << n.own;
                end
            end
            1, 2, 3: begin
                if (!rq[s.own]) begin
                    n.ph = 5; n.off = 1'b1;
                end else if (s.ph == 1) begin
                    if (to == 8'h00) begin
                        n.ph = 2; n.ok = 1'b1;
                    end else begin
                        n.wt = s.wt + 1;
                        if (n.wt >= TIMEOUT) begin n.er = 1'b1; n.ph = 5; n.off = 1'b1; end
                    end
                end else if (s.ph == 2) begin
                    n.ph = 3;
                end else if (to == 8'hFF) begin
                    n.ph = 4; n.d = s.g;
                end
            end
            default: begin
                n.ph = 0; n.g = 4'd0; n.ptr = (s.own + 1) % 4;
            end
        endcase
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m, reset, req, req_value, tmr_out);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_grant", grant, m.g);
            chk("m_done", done, m.d);
            chk("m_err", err, m.er);
            chk("m_busy", busy, m.ph != 0);
            chk("m_tmr_on", tmr_on, m.on);
            chk("m_tmr_off", tmr_off, m.off);
            chk("m_tmr_ok", tmr_ok, m.ok);
            chk("m_tmr_mode", tmr_mode, 1'b0);
            chk("m_tmr_value", tmr_value, m.val[7:0]);
        end
    end

    function automatic logic cond(input int what);
        case (what)
            0: return grant != 4'd0;
            1: return tmr_out == 8'd5;
            2: return grant == 4'd0;
            3: return done != 4'd0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int what, input string nm);
        int n = 0;
        while (!cond(what) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cond(what)) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: condition not reached within 200 cycles", nm);
        end
    endtask

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_grant", grant, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_value", tmr_value, 8'd0);
        reset = 1'b0;

        // Single request, power-up of 3 cycles: ok 5 cycles and done 12 cycles after grant
        req_value = 32'h0000_0300;
        req = 4'b0010;
        wait_for(0, "single_grant_wait");
        chk("single_grant", grant, 4'b0010);
        chk("single_on", tmr_on, 1'b1);
        repeat (5) @(negedge clk);
        chk("single_ok", tmr_ok, 1'b1);
        chk("single_value", tmr_value, 8'd3);
        repeat (7) @(negedge clk);
        chk("single_done", done, 4'b0010);
        req = 4'd0;
        @(negedge clk);
        chk("single_release", grant, 4'd0);
        chk("single_idle", busy, 1'b0);

        // Round robin from a fresh reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_value = 32'h0102_0304;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_for(0, "rr_grant_wait");
            chk("rr_order", grant, rr_exp[i]);
            wait_for(3, "rr_done_wait");
            wait_for(2, "rr_idle_wait");
        end
        req = 4'd0;

        // Cancel during the count at tmr_out==5
        req_value = 32'h0008_0000;
        req = 4'b0100;
        wait_for(1, "cancel_count_wait");
        req = 4'd0;
        @(negedge clk);
        chk("cancel_off", tmr_off, 1'b1);
        chk("cancel_no_done", done, 4'd0);
        @(negedge clk);
        chk("cancel_grant", grant, 4'd0);
        chk("cancel_off_pulse", tmr_off, 1'b0);
        chk("cancel_busy", busy, 1'b0);
        req = 4'b1001;
        wait_for(0, "cancel_ptr_wait");
        chk("cancel_ptr", grant, 4'b1000);
        req = 4'd0;
        wait_for(2, "cancel2_idle_wait");

        // Timeout with the timer stuck in power-up
        force_stuck = 1'b1;
        req = 4'b0001;
        wait_for(0, "to_grant_wait");
        chk("to_grant", grant, 4'b0001);
        repeat (14) @(negedge clk);
        chk("to_err_early", err, 1'b0);
        chk("to_busy", busy, 1'b1);
        @(negedge clk);
        chk("to_err", err, 1'b1);
        chk("to_off", tmr_off, 1'b1);
        req = 4'd0;
        @(negedge clk);
        chk("to_err_pulse", err, 1'b0);
        chk("to_idle", busy, 1'b0);
        force_stuck = 1'b0;

        // Zero value, immediate power-up: ok 3 and done 7 cycles after grant
        fixed_pu = 0;
        req_value = 32'd0;
        req = 4'b0001;
        wait_for(0, "zero_grant_wait");
        repeat (3) @(negedge clk);
        chk("zero_ok", tmr_ok, 1'b1);
        chk("zero_value", tmr_value, 8'd0);
        repeat (3) @(negedge clk);
        chk("zero_done_early", done, 4'd0);
        @(negedge clk);
        chk("zero_done", done, 4'b0001);
        req = 4'd0;
        @(negedge clk);

        // Reset while counting
        req_value = 32'h0000_0A00;
        req = 4'b0010;
        wait_for(0, "rst_run_grant_wait");
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rrun_grant", grant, 4'd0);
        chk("rrun_busy", busy, 1'b0);
        chk("rrun_value", tmr_value, 8'd0);
        chk("rrun_off", tmr_off, 1'b0);
        reset = 1'b0;
        req = 4'b1111;
        wait_for(0, "rrun_next_wait");
        chk("rrun_next", grant, 4'b0001);
        req = 4'd0;
        wait_for(2, "rrun_idle_wait");

        // Randomized traffic against the model
        fixed_pu = -1;
        rand_timer = 1'b1;
        repeat (4000) begin
            @(negedge clk);
            reset = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if (done[i] || $urandom_range(0, 59) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) begin
                    req[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                req_value[8*$urandom_range(0, 3) +: 8] = 8'($urandom_range(0, 12));
            end
        end
        reset = 1'b0;
        req = 4'd0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
